// File: rtl/ssram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ssram_ctrl : initiator for a 36-bit pipelined (ZBT) SSRAM, credit-checked read FIFO
// Revision   : 1.0
// ---------------------------------------------------------------------------
module ssram_ctrl #(
  parameter int ADDR_W        = 28,
  parameter int RD_FIFO_DEPTH = 4,
  parameter int INIT_CYCLES   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [35:0]       i_cmd_wdata,
  input  logic [3:0]        i_cmd_be,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [35:0]       o_rd_data,
  output logic              o_init_done,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [8:0]        io_sram_da,
  inout  wire  [8:0]        io_sram_db,
  inout  wire  [8:0]        io_sram_dc,
  inout  wire  [8:0]        io_sram_dd,
  output logic              o_sram_wen,
  output logic              o_sram_oen,
  output logic              o_sram_cen,
  output logic              o_sram_bwan,
  output logic              o_sram_bwbn,
  output logic              o_sram_bwcn,
  output logic              o_sram_bwdn,
  output logic              o_sram_ce2,
  output logic              o_sram_ce2n,
  output logic              o_sram_mode,
  output logic              o_sram_clken,
  output logic              o_sram_zz,
  output logic              o_sram_adv,
  output logic              o_sram_clk
);
  localparam int PTR_W  = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [INIT_W-1:0]   r_init_cnt;
  logic                w_init_last;
  logic                w_accept, w_rd_issue, w_push, w_pop, w_full;
  logic [CNT_W-1:0]    r_inflight, r_count, w_credit;
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [35:0]         r_fifo [RD_FIFO_DEPTH];
  logic [35:0]         w_lanes;
  logic                r_cen, r_wen;
  logic [3:0]          r_bwn;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_c_vld, r_c_wr, r_p1_vld, r_p1_wr, r_p2_vld, r_p2_wr;
  logic [35:0]         r_c_wdata, r_p1_wdata, r_p2_wdata;
  logic                w_drv;

  assign w_init_last = (r_init_cnt == INIT_W'(INIT_CYCLES - 1));
  assign w_credit    = r_inflight + r_count;
  assign w_accept    = i_cmd_valid & o_cmd_ready;
  assign w_rd_issue  = w_accept & ~i_cmd_write;

  always_comb begin
    w_state_nxt = r_state;
    o_init_done = 1'b0;
    o_cmd_ready = 1'b0;
    case (r_state)
      S_INIT: begin
        if (w_init_last) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_init_done = 1'b1;
        // Reserve a FIFO slot for every read already on the bus
        o_cmd_ready = (w_credit < CNT_W'(RD_FIFO_DEPTH));
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + INIT_W'(1);
    end
  end

  // Command cycle C, then C+1 and C+2 stages; data phase lives in C+2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cen      <= 1'b1;
      r_wen      <= 1'b1;
      r_bwn      <= 4'hF;
      r_addr     <= '0;
      r_c_vld    <= 1'b0;
      r_c_wr     <= 1'b0;
      r_c_wdata  <= '0;
      r_p1_vld   <= 1'b0;
      r_p1_wr    <= 1'b0;
      r_p1_wdata <= '0;
      r_p2_vld   <= 1'b0;
      r_p2_wr    <= 1'b0;
      r_p2_wdata <= '0;
    end else begin
      r_cen      <= ~w_accept;
      r_wen      <= ~(w_accept & i_cmd_write);
      r_bwn      <= (w_accept & i_cmd_write) ? ~i_cmd_be : 4'hF;
      if (w_accept) r_addr <= i_cmd_addr;
      r_c_vld    <= w_accept;
      r_c_wr     <= i_cmd_write;
      r_c_wdata  <= i_cmd_wdata;
      r_p1_vld   <= r_c_vld;
      r_p1_wr    <= r_c_wr;
      r_p1_wdata <= r_c_wdata;
      r_p2_vld   <= r_p1_vld;
      r_p2_wr    <= r_p1_wr;
      r_p2_wdata <= r_p1_wdata;
    end
  end

  assign w_drv      = r_p2_vld & r_p2_wr;
  assign io_sram_da = w_drv ? r_p2_wdata[8:0]   : 9'bz;
  assign io_sram_db = w_drv ? r_p2_wdata[17:9]  : 9'bz;
  assign io_sram_dc = w_drv ? r_p2_wdata[26:18] : 9'bz;
  assign io_sram_dd = w_drv ? r_p2_wdata[35:27] : 9'bz;
  assign w_lanes    = {io_sram_dd, io_sram_dc, io_sram_db, io_sram_da};

  assign w_push     = r_p2_vld & ~r_p2_wr;
  assign w_pop      = o_rd_valid & i_rd_ready;
  assign w_full     = (r_count == CNT_W'(RD_FIFO_DEPTH));
  assign o_rd_valid = (r_count != '0);
  assign o_rd_data  = o_rd_valid ? r_fifo[r_rptr] : 36'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
    end else begin
      assert (!(w_push && w_full));
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
      case ({w_rd_issue, w_push})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_lanes;
  end

  assign o_sram_addr  = r_addr;
  assign o_sram_cen   = r_cen;
  assign o_sram_wen   = r_wen;
  assign o_sram_bwan  = r_bwn[0];
  assign o_sram_bwbn  = r_bwn[1];
  assign o_sram_bwcn  = r_bwn[2];
  assign o_sram_bwdn  = r_bwn[3];
  assign o_sram_oen   = ~((r_p1_vld & ~r_p1_wr) | (r_p2_vld & ~r_p2_wr));
  assign o_sram_ce2   = 1'b1;
  assign o_sram_ce2n  = 1'b0;
  assign o_sram_mode  = 1'b0;
  assign o_sram_clken = 1'b0;
  assign o_sram_zz    = 1'b0;
  assign o_sram_adv   = 1'b0;
  assign o_sram_clk   = clk;

endmodule
`default_nettype wire

// File: tb/tb_ssram_ctrl.sv
`default_nettype none
// tb_ssram_ctrl : scoreboard bench for ssram_ctrl driving a behavioural ZBT SRAM model.
// Released lanes are pulled high, so a floating bus reads as all ones.
module tb_ssram_ctrl;
  localparam int ADDR_W = 28;
  localparam logic [35:0] ONES = 36'hF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [35:0]       cmd_wdata = '0;
  logic [3:0]        cmd_be = '0;
  logic              rd_ready = 1'b1;

  wire              cmd_ready, rd_valid, init_done;
  wire [35:0]       rd_data;
  wire [ADDR_W-1:0] s_addr;
  wire [8:0]        s_da, s_db, s_dc, s_dd;
  wire              s_wen, s_oen, s_cen, s_bwa, s_bwb, s_bwc, s_bwd;
  wire              s_ce2, s_ce2n, s_mode, s_clken, s_zz, s_adv, s_clk;
  wire [35:0]       lanes = {s_dd, s_dc, s_db, s_da};
  wire [3:0]        bwn   = {s_bwd, s_bwc, s_bwb, s_bwa};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar i = 0; i < 9; i++) begin : g_pull
    pullup (s_da[i]);
    pullup (s_db[i]);
    pullup (s_dc[i]);
    pullup (s_dd[i]);
  end

  ssram_ctrl #(.ADDR_W(ADDR_W), .RD_FIFO_DEPTH(4), .INIT_CYCLES(256)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_be(cmd_be),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
    .o_init_done(init_done), .o_sram_addr(s_addr),
    .io_sram_da(s_da), .io_sram_db(s_db), .io_sram_dc(s_dc), .io_sram_dd(s_dd),
    .o_sram_wen(s_wen), .o_sram_oen(s_oen), .o_sram_cen(s_cen),
    .o_sram_bwan(s_bwa), .o_sram_bwbn(s_bwb), .o_sram_bwcn(s_bwc), .o_sram_bwdn(s_bwd),
    .o_sram_ce2(s_ce2), .o_sram_ce2n(s_ce2n), .o_sram_mode(s_mode),
    .o_sram_clken(s_clken), .o_sram_zz(s_zz), .o_sram_adv(s_adv), .o_sram_clk(s_clk)
  );

  // ZBT device model: command sampled at end of C, data edge at end of C+2
  logic [35:0] mem [0:1023];
  logic        m1_vld = 1'b0, m1_wr = 1'b0, m2_vld = 1'b0, m2_wr = 1'b0;
  logic [9:0]  m1_a = '0, m2_a = '0;
  logic [3:0]  m1_bw = 4'hF, m2_bw = 4'hF;

  initial for (int i = 0; i < 1024; i++) mem[i] = 36'h0;

  always @(posedge clk) begin
    if (m2_vld && m2_wr)
      for (int i = 0; i < 4; i++)
        if (!m2_bw[i]) mem[m2_a][i*9 +: 9] = lanes[i*9 +: 9];
    m2_vld <= m1_vld;  m2_wr <= m1_wr;  m2_a <= m1_a;  m2_bw <= m1_bw;
    m1_vld <= !s_cen;  m1_wr <= !s_wen; m1_a <= s_addr[9:0]; m1_bw <= bwn;
  end

  wire        m_drv = m2_vld && !m2_wr && !s_oen;
  wire [35:0] m_q   = mem[m2_a];
  assign s_da = m_drv ? m_q[8:0]   : 9'bz;
  assign s_db = m_drv ? m_q[17:9]  : 9'bz;
  assign s_dc = m_drv ? m_q[26:18] : 9'bz;
  assign s_dd = m_drv ? m_q[35:27] : 9'bz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every read return popped by the consumer is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read return", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [35:0] pat(input int j);
    return {4'(j), 8'(j * 3), 8'hC3, 8'(j), 8'h5A};
  endfunction

  // Called at a negedge; returns at the negedge of the command cycle C
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [35:0] d,
                       input logic [3:0] be, input logic [35:0] exp);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_be = be;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", cmd_ready, 1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    if (!wr) exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic reset_and_init();
    int n = 0;
    logic cen_idle = 1'b1;
    rst = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_strobes", {s_cen, s_wen, s_oen, bwn}, 7'h7F);
    chk("rst_lanes_z", lanes, ONES);
    rst = 1'b0;
    while (!cmd_ready && n < 1000) begin
      cen_idle &= s_cen;
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    chk("init_cycles", n, 256);
    chk("init_done", init_done, 1);
    chk("init_cen_idle", cen_idle, 1);
  endtask

  initial begin
    int n, acc, t0;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, acc, t0;
    reset_and_init();
    chk("rst_addr", s_addr, 0);
    chk("static_pins", {s_ce2, s_ce2n, s_mode, s_clken, s_zz, s_adv, s_clk}, 7'b1000000);

    // Write then read back, with bus timing checks
    issue(1'b1, 28'h0000123, 36'h1_2345_6789, 4'hF, '0);
    chk("wr_cmd_strobes", {s_cen, s_wen, bwn}, 6'b000000);
    chk("wr_cmd_addr", s_addr, 28'h0000123);
    chk("wr_lanes_c", lanes, ONES);
    @(negedge clk);
    chk("wr_lanes_c1", lanes, ONES);
    chk("wr_oen", s_oen, 1);
    @(negedge clk);
    chk("wr_lanes_c2", lanes, 36'h1_2345_6789);
    @(negedge clk);
    chk("wr_lanes_c3", lanes, ONES);
    issue(1'b0, 28'h0000123, '0, 4'h0, 36'h1_2345_6789);
    chk("rd_cmd_strobes", {s_cen, s_wen}, 2'b01);
    n = 1;
    while (!rd_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rd_latency", n, 4);
    repeat (2) @(negedge clk);

    // Byte-lane masking
    issue(1'b1, 28'd5, 36'h0, 4'hF, '0);
    issue(1'b1, 28'd5, ONES, 4'b0101, '0);
    chk("bw_mask", bwn, 4'b1010);
    issue(1'b0, 28'd5, '0, 4'h0, 36'h0_07FC_01FF);
    repeat (6) @(negedge clk);

    // Streaming alternating write/read, no bubbles expected
    t0 = cyc;
    for (int j = 0; j < 32; j++) begin
      issue(1'b1, 28'h200 + 28'(j), pat(j), 4'hF, '0);
      issue(1'b0, 28'h200 + 28'(j), '0, 4'h0, pat(j));
    end
    chk("stream_cycles", cyc - t0, 64);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stream_drained", exp_q.size(), 0);

    // Backpressure: only four reads fit under the credit limit
    rd_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 28'h200 + 28'(acc);
      if (cmd_ready) begin
        exp_q.push_back(pat(acc));
        acc++;
      end
      @(negedge clk);
    end
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", cmd_ready, 0);
    chk("bp_rd_valid", rd_valid, 1);
    rd_ready = 1'b1;
    n = 0;
    while (acc < 8 && n < 50) begin
      cmd_valid = 1'b1; cmd_addr = 28'h200 + 28'(acc);
      if (cmd_ready) begin
        exp_q.push_back(pat(acc));
        acc++;
      end
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    chk("bp_resumed", acc, 8);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_drained", exp_q.size(), 0);

    // Reset one cycle after a write handshake
    issue(1'b1, 28'h40, ONES, 4'hF, '0);
    repeat (3) @(negedge clk);
    rd_ready = 1'b0;
    issue(1'b0, 28'h123, '0, 4'h0, 36'h1_2345_6789);
    repeat (4) @(negedge clk);
    chk("mid_rd_pending", rd_valid, 1);
    issue(1'b1, 28'h40, 36'h0, 4'hF, '0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_lanes_c1", lanes, ONES);
    chk("mid_rd_valid", rd_valid, 0);
    chk("mid_init_state", {init_done, cmd_ready}, 2'b00);
    @(negedge clk);
    chk("mid_lanes_c2", lanes, ONES);
    rd_ready = 1'b1;
    reset_and_init();
    issue(1'b0, 28'h40, '0, 4'h0, ONES);
    repeat (10) @(negedge clk);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ssram_ctrl.md
Name: ssram_ctrl

Overview:
- Initiator-side controller for the 36-bit pipelined (ZBT-style) synchronous SRAM: four 9-bit lanes DA/DB/DC/DD, 28-bit address.
- Turns a valid/ready command stream from user logic (optical-flow frame buffer) into single-beat bus cycles with no bursts.
- Drives write data exactly two device edges after the command and captures read data at the same point.
- Returns read data through a small FIFO with backpressure; credit accounting guarantees no read return is ever dropped.

Parameters:
- ADDR_W, 28, SRAM address width
- RD_FIFO_DEPTH, 4, read-return FIFO entries (power of two, >=4)
- INIT_CYCLES, 256, idle cycles after reset before the first command is accepted

Ports:
- clk  in  1  system clock; also forwarded to SRAM_CLK
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  word address
- cmd_wdata  in  36  write data: [8:0]=DA, [17:9]=DB, [26:18]=DC, [35:27]=DD
- cmd_be  in  4  byte-lane enables, active-high; bit0=DA … bit3=DD
- rd_valid  out  1  read data available
- rd_ready  in  1  consumer accepts read data
- rd_data  out  36  read data, same lane packing as cmd_wdata
- init_done  out  1  high once INIT completes
- SRAM_ADDR  out  ADDR_W  registered address
- SRAM_DA, SRAM_DB, SRAM_DC, SRAM_DD  inout  9 each  data lanes
- SRAM_WEn, SRAM_OEn, SRAM_CEn  out  1 each  active-low strobes
- SRAM_BWan, SRAM_BWbn, SRAM_BWcn, SRAM_BWdn  out  1 each  active-low lane writes
- SRAM_CE2, SRAM_CE2n, SRAM_MODE, SRAM_CLKEn, SRAM_ZZ, SRAM_ADV  out  1 each  static strapping
- SRAM_CLK  out  1  forwarded clk

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Static pins:
  - SRAM_CE2=1, SRAM_CE2n=0, SRAM_MODE=0, SRAM_CLKEn=0, SRAM_ZZ=0, SRAM_ADV=0.
  - SRAM_CLK=clk, combinational forward.
- Reset values:
  - cmd_ready=0, rd_valid=0, rd_data=0, init_done=0.
  - SRAM_CEn=1, SRAM_WEn=1, SRAM_OEn=1, all BWxn=1, SRAM_ADDR=0.
  - Data lanes released (Z).
  - FIFO and credit counter cleared; all pipeline stages invalid.
- FSM INIT -> RUN:
  - INIT counts INIT_CYCLES clocks with NOPs on the bus, then enters RUN and sets init_done.
  - Only rst returns the FSM to INIT.
- Issue: in RUN, a handshake in cycle t registers the command onto the bus, stable during cycle t+1 (the command cycle C).
  - Read: CEn=0, WEn=1.
  - Write: CEn=0, WEn=0, BWxn=~cmd_be.
  - Cycles with no accepted command are NOPs: CEn=1, WEn=1, BWxn=1.
- Pipeline: the device samples the command at the end of C.
  - Data edge = end of cycle C+2, a fixed 2-edge latency.
  - A two-stage shift register carries {valid, write, wdata} to the data cycle.
- Write data:
  - Lanes driven with wdata only during cycle C+2; Z otherwise.
  - Lanes whose cmd_be bit is 0 are still driven (don't-care); the device masks them with BWxn.
- Read data:
  - SRAM_OEn=0 during cycles C+1 and C+2 of each read; 1 otherwise.
  - Lanes are sampled at the end of C+2 and pushed into the FIFO; rd_valid can assert in cycle C+3 at the earliest.
  - End-to-end minimum read latency is 4 clocks from the handshake.
- Back-to-back operation: reads and writes may be issued every cycle in any mix.
  - No turnaround bubble is inserted, since the ZBT protocol needs none.
  - The data phases of consecutive commands follow in command order.
- Credits:
  - inflight = reads issued but not yet pushed; count = FIFO occupancy.
  - cmd_ready = RUN && (inflight + count < RD_FIFO_DEPTH).
  - cmd_ready is computed conservatively for both reads and writes, so it is independent of cmd_write.
- FIFO:
  - Show-ahead output: rd_data is valid whenever rd_valid=1.
  - A pop occurs on rd_valid && rd_ready.
  - Simultaneous push and pop in one cycle leaves count unchanged and preserves order.
  - Pointers wrap modulo RD_FIFO_DEPTH. Overflow is impossible by credit; a push when full is an assertion failure.
- Reset mid-operation: all in-flight commands are discarded and writes in the pipeline are not completed.
  - Lanes go Z on the next edge.
  - FIFO is flushed and the FSM returns to INIT.
- Widths: inflight+count is computed at log2(RD_FIFO_DEPTH)+1 bits, so there is no wrap.

Test Plan:
- Init: rst for 2 cycles, cmd_valid=1 held -> cmd_ready=0 and CEn=1 for 256 cycles, then init_done=1 and cmd_ready=1 in the same cycle.
- Write/readback:
  - Stimulus: write addr 0x0000123, data 36'h1_2345_6789, be=4'hF; then read 0x0000123.
  - Response: WEn=0 in the write command cycle, lanes driven exactly 2 cycles later; rd_data=36'h1_2345_6789 four cycles after the read handshake.
- Byte lanes:
  - Stimulus: write addr 5 with 36'h0, be=F; then write addr 5 with 36'hF_FFFF_FFFF, be=4'b0101; then read addr 5.
  - Response: lane DA=9'h1FF, DB=9'h000, DC=9'h1FF, DD=9'h000, i.e. rd_data=36'h0_07FC_01FF.
- Streaming mix:
  - Stimulus: 64 alternating write/read commands to incrementing addresses, cmd_valid held high, rd_ready=1.
  - Response: one command per cycle with no bubbles; all 32 reads return the matching data in order.
- Backpressure:
  - Stimulus: rd_ready=0 while issuing 8 reads.
  - Response: exactly 4 accepted, then cmd_ready=0; after rd_ready=1, the 4 results drain in order and issue resumes.
- Reset mid-flight:
  - Stimulus: rst asserted 1 cycle after a write handshake.
  - Response: lanes Z on the next edge, the memory location is unchanged, rd_valid=0, and the FSM is back in INIT.
